uart_slip_decoder: RTL and testbench
====================================

Name: uart_slip_decoder

Overview:
- Sits directly downstream of the UART receiver's byte output, and consumes its 8-bit valid/ready byte stream.
- Decodes SLIP framing (RFC 1055): END 0xC0, ESC 0xDB, ESC_END 0xDC, ESC_ESC 0xDD.
- Emits decoded payload bytes with a last marker and an error sideband, plus frame/error statistics for the register block.
- Holds one byte of lookahead so that last is attached to the final payload byte itself.

Parameters:
MAX_LEN, 256, maximum decoded payload bytes per frame; one more triggers overlength error
CNT_W, $clog2(MAX_LEN+1), width of the length counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
enable_i  in  1  decoder enable; low blocks input acceptance, state is held
in_d_i  in  8  raw byte from UART receiver
in_valid_i  in  1  raw byte valid
in_ready_o  out  1  raw byte accepted when in_valid_i & in_ready_o
out_d_o  out  8  decoded payload byte
out_valid_o  out  1  decoded byte valid
out_last_o  out  1  final byte of frame (qualified by out_valid_o)
out_err_o  out  1  frame terminated by error (only with out_last_o)
out_ready_i  in  1  downstream accepts byte
frame_done_o  out  1  1-cycle pulse, good frame completed
frame_len_o  out  CNT_W  length of last good frame
err_esc_o  out  1  1-cycle pulse, illegal escape sequence
err_overlen_o  out  1  1-cycle pulse, frame exceeded MAX_LEN
frame_cnt_o  out  16  good frames, saturating
err_cnt_o  out  16  error events, saturating

Behaviour:
- Reset (async on rst high): state=HUNT, hold empty, count=0, all outputs 0 including counters.
- A reset mid-frame discards the frame silently.
- Accept rule: in_ready_o = enable_i & (~out_valid_o | out_ready_i). At most one byte is accepted per cycle, and at most one push into the output register per cycle.
- Output register: loads on a push. out_valid_o clears on handshake with no new push. Contents stay stable while out_valid_o & ~out_ready_i.
- Hold register (1 byte + valid): the lookahead. A data byte pushes any previous hold byte out with last=0, then becomes the new hold byte.
- Latency: a payload byte appears on out one cycle after the next raw byte (data or END) is accepted.
- "Decoded byte d" handling:
  - If count==MAX_LEN: overlength error.
  - Otherwise: push hold (last=0) if valid, hold=d, count++.
- "Terminate-with-error":
  - If hold valid: push hold with last=1, err=1; clear hold.
  - Then count=0, pulse the relevant error output, err_cnt++.
- State machine (transitions on accepted bytes only):
  - HUNT: discard bytes until 0xC0, then go to DATA.
  - DATA, byte 0xC0:
    - Hold valid: push hold with last=1, err=0; frame_len_o<=count; frame_done_o pulse; frame_cnt++; count=0; hold cleared.
    - Hold empty: empty frame, ignored; no pulse.
    - Stay in DATA.
  - DATA, byte 0xDB: go to ESC.
  - DATA, other byte: decoded byte d=byte.
  - ESC, 0xDC: decoded 0xC0, go to DATA.
  - ESC, 0xDD: decoded 0xDB, go to DATA.
  - ESC, 0xC0: err_esc, terminate-with-error, go to DATA (the END doubles as delimiter).
  - ESC, other byte: err_esc, terminate-with-error, go to DROP.
  - Overlength (from DATA or ESC): err_overlen, terminate-with-error, go to DROP. The offending byte is discarded.
  - DROP: discard bytes until 0xC0, then go to DATA with count=0; no output.
- Status outputs:
  - frame_done_o, err_esc_o and err_overlen_o are registered; they assert in the same cycle out_last_o first becomes visible (for errors with an empty hold, the cycle after acceptance).
  - Counters saturate at 16'hFFFF.
- enable_i low mid-frame: acceptance stops; state, hold and count are kept, and output drains normally.

Decomposition:
- Add to the shared uart_defs package: SLIP_END, SLIP_ESC, SLIP_ESC_END, SLIP_ESC_ESC byte constants, and the SlipState_t enum {HUNT, DATA, ESC, DROP}.
- Single module. No sub-module is natural; the output register and hold register stay inline.

Test Plan:
- Reset, then C0 01 02 03 C0 with out_ready_i=1 -> out 01,02,03 with last only on 03; frame_done pulse; frame_len_o=3; frame_cnt_o=1.
- Bytes 55 C0 DB DC DB DD C0 after reset -> 55 dropped (HUNT); out C0, DB(last); frame_len_o=2.
- C0 C0 C0 -> no output, no frame_done, frame_cnt_o unchanged.
- C0 AA DB 11 BB C0 -> out AA with last=1, err=1; err_esc_o pulse; BB dropped; err_cnt_o=1; next frame C0 77 C0 decodes 77 normally.
- MAX_LEN=4: C0 01 02 03 04 05 06 C0 -> 01,02,03 last=0, 04 last=1 err=1; err_overlen_o pulse; 05,06 dropped.
- Downstream stall: hold out_ready_i=0 for 5 cycles mid-frame -> in_ready_o=0, out_d_o stable, no byte lost. Assert rst mid-frame -> all outputs 0, state HUNT.

Source files
------------

// File: rtl/uart_defs_pkg.sv
// Shared UART definitions: SLIP framing byte codes, decoder state type and
// a saturating counter helper.
package uart_defs;

  localparam logic [7:0] SLIP_END     = 8'hC0;
  localparam logic [7:0] SLIP_ESC     = 8'hDB;
  localparam logic [7:0] SLIP_ESC_END = 8'hDC;
  localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    DATA = 2'd1,
    ESC  = 2'd2,
    DROP = 2'd3
  } SlipState_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/uart_slip_decoder.sv
// SLIP (RFC 1055) frame decoder with one byte of lookahead so that the
// last marker rides on the final payload byte, plus frame/error statistics.
module uart_slip_decoder
  import uart_defs::*;
#(
  parameter int MAX_LEN = 256,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic [7:0]       in_d_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [7:0]       out_d_o,
  output logic             out_valid_o,
  output logic             out_last_o,
  output logic             out_err_o,
  input  logic             out_ready_i,
  output logic             frame_done_o,
  output logic [CNT_W-1:0] frame_len_o,
  output logic             err_esc_o,
  output logic             err_overlen_o,
  output logic [15:0]      frame_cnt_o,
  output logic [15:0]      err_cnt_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

  SlipState_t       state_r, state_nx;
  logic [7:0]       hold_d_r, hold_d_nx;
  logic             hold_v_r, hold_v_nx;
  logic [CNT_W-1:0] count_r, count_nx;

  logic       accept;
  logic       push;
  logic [7:0] push_d;
  logic       push_last;
  logic       push_err;
  logic       dec_v;
  logic [7:0] dec_b;
  logic       done_ev;
  logic       esc_ev;
  logic       ovl_ev;

  // A byte may only enter when the output register is free or draining this cycle.
  assign in_ready_o = enable_i & (~out_valid_o | out_ready_i);
  assign accept     = in_valid_i & in_ready_o;

  always_comb begin
    state_nx  = state_r;
    hold_d_nx = hold_d_r;
    hold_v_nx = hold_v_r;
    count_nx  = count_r;
    push      = 1'b0;
    push_d    = hold_d_r;
    push_last = 1'b0;
    push_err  = 1'b0;
    dec_v     = 1'b0;
    dec_b     = in_d_i;
    done_ev   = 1'b0;
    esc_ev    = 1'b0;
    ovl_ev    = 1'b0;

    if (accept) begin
      case (state_r)
        HUNT: begin
          if (in_d_i == SLIP_END) state_nx = DATA;
          else                    state_nx = HUNT;
        end
        DATA: begin
          if (in_d_i == SLIP_END) begin
            if (hold_v_r) begin
              push      = 1'b1;
              push_last = 1'b1;
              done_ev   = 1'b1;
              hold_v_nx = 1'b0;
            end else begin
              push      = 1'b0;
            end
            count_nx = '0;
          end else if (in_d_i == SLIP_ESC) begin
            state_nx = ESC;
          end else begin
            dec_v = 1'b1;
          end
        end
        ESC: begin
          case (in_d_i)
            SLIP_ESC_END: begin
              dec_v    = 1'b1;
              dec_b    = SLIP_END;
              state_nx = DATA;
            end
            SLIP_ESC_ESC: begin
              dec_v    = 1'b1;
              dec_b    = SLIP_ESC;
              state_nx = DATA;
            end
            // A bad escape followed by END still delimits the next frame.
            SLIP_END: begin
              esc_ev   = 1'b1;
              state_nx = DATA;
            end
            default: begin
              esc_ev   = 1'b1;
              state_nx = DROP;
            end
          endcase
        end
        DROP: begin
          if (in_d_i == SLIP_END) begin
            state_nx = DATA;
            count_nx = '0;
          end else begin
            state_nx = DROP;
          end
        end
        default: state_nx = HUNT;
      endcase
    end else begin
      dec_v = 1'b0;
    end

    // Decoded byte: shift the lookahead byte out and take its place.
    if (dec_v) begin
      if (count_r == MAX_CNT) begin
        ovl_ev   = 1'b1;
        state_nx = DROP;
      end else begin
        if (hold_v_r) begin
          push = 1'b1;
        end else begin
          push = 1'b0;
        end
        hold_d_nx = dec_b;
        hold_v_nx = 1'b1;
        count_nx  = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      dec_v = 1'b0;
    end

    if (esc_ev | ovl_ev) begin
      if (hold_v_r) begin
        push      = 1'b1;
        push_last = 1'b1;
        push_err  = 1'b1;
      end else begin
        push      = 1'b0;
      end
      hold_v_nx = 1'b0;
      count_nx  = '0;
    end else begin
      ovl_ev = 1'b0;
    end
  end

  // Decoder state, lookahead byte and frame length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= HUNT;
      hold_d_r <= 8'h00;
      hold_v_r <= 1'b0;
      count_r  <= '0;
    end else begin
      state_r  <= state_nx;
      hold_d_r <= hold_d_nx;
      hold_v_r <= hold_v_nx;
      count_r  <= count_nx;
    end
  end

  // Output register: contents held while stalled, valid drops after a handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_d_o     <= 8'h00;
      out_valid_o <= 1'b0;
      out_last_o  <= 1'b0;
      out_err_o   <= 1'b0;
    end else if (push) begin
      out_d_o     <= push_d;
      out_valid_o <= 1'b1;
      out_last_o  <= push_last;
      out_err_o   <= push_err;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
      out_last_o  <= 1'b0;
      out_err_o   <= 1'b0;
    end
  end

  // Status pulses and saturating statistics, aligned with the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_done_o  <= 1'b0;
      frame_len_o   <= '0;
      err_esc_o     <= 1'b0;
      err_overlen_o <= 1'b0;
      frame_cnt_o   <= 16'h0000;
      err_cnt_o     <= 16'h0000;
    end else begin
      frame_done_o  <= done_ev;
      err_esc_o     <= esc_ev;
      err_overlen_o <= ovl_ev;
      if (done_ev) begin
        frame_len_o <= count_r;
        frame_cnt_o <= sat_inc16(frame_cnt_o);
      end
      if (esc_ev | ovl_ev) begin
        err_cnt_o <= sat_inc16(err_cnt_o);
      end
    end
  end

endmodule

// File: tb/tb_uart_slip_decoder.sv
// Self-checking bench for uart_slip_decoder: directed scenarios plus random
// byte streams scored against a frame-level SLIP reference model.
module tb_uart_slip_decoder;

  localparam int MAX_LEN = 4;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);
  localparam int M_HUNT = 0, M_DATA = 1, M_ESC = 2, M_DROP = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic [7:0]       in_d = 8'h00;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       out_d;
  logic             out_valid, out_last, out_err;
  logic             out_ready = 1'b0;
  logic             frame_done, err_esc, err_overlen;
  logic [CNT_W-1:0] frame_len;
  logic [15:0]      frame_cnt, err_cnt;

  int checks = 0;
  int errors = 0;
  int ready_mode = 0;

  // Reference model: whole frames are collected, then emitted with last/err on the final byte.
  logic [9:0]  exp_q[$];
  logic [9:0]  got_q[$];
  logic [7:0]  cur[$];
  int          m_mode;
  logic [15:0] m_frames, m_errs;
  int          m_len, m_done, m_esc, m_ovl;
  int          s_done, s_esc, s_ovl;
  logic [7:0]  held_d;

  uart_slip_decoder #(.MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst), .enable_i(enable),
    .in_d_i(in_d), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .out_d_o(out_d), .out_valid_o(out_valid), .out_last_o(out_last),
    .out_err_o(out_err), .out_ready_i(out_ready),
    .frame_done_o(frame_done), .frame_len_o(frame_len),
    .err_esc_o(err_esc), .err_overlen_o(err_overlen),
    .frame_cnt_o(frame_cnt), .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) got_q.push_back({out_d, out_last, out_err});
      if (frame_done) begin
        s_done++;
        checks++;
        if (!(out_valid && out_last && !out_err)) begin
          errors++;
          $display("FAIL done_align valid=%b last=%b err=%b required 1 1 0", out_valid, out_last, out_err);
        end
      end
      if (err_esc) s_esc++;
      if (err_overlen) s_ovl++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_mode = M_HUNT;
    cur.delete(); exp_q.delete(); got_q.delete();
    m_frames = 16'd0; m_errs = 16'd0;
    m_len = 0; m_done = 0; m_esc = 0; m_ovl = 0;
    s_done = 0; s_esc = 0; s_ovl = 0;
  endtask

  task automatic model_flush(input bit e);
    int n;
    n = cur.size();
    for (int i = 0; i < n; i++) exp_q.push_back({cur[i], (i == n - 1), (e && (i == n - 1))});
    cur.delete();
  endtask

  task automatic model_err(input bit ovl);
    model_flush(1'b1);
    if (m_errs != 16'hFFFF) m_errs = m_errs + 16'd1;
    if (ovl) m_ovl++; else m_esc++;
  endtask

  task automatic model_add(input logic [7:0] d);
    if (cur.size() == MAX_LEN) begin
      model_err(1'b1);
      m_mode = M_DROP;
    end else begin
      cur.push_back(d);
      m_mode = M_DATA;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    case (m_mode)
      M_HUNT: if (b == 8'hC0) m_mode = M_DATA;
      M_DATA: begin
        if (b == 8'hC0) begin
          if (cur.size() > 0) begin
            m_len = cur.size();
            model_flush(1'b0);
            if (m_frames != 16'hFFFF) m_frames = m_frames + 16'd1;
            m_done++;
          end
        end else if (b == 8'hDB) m_mode = M_ESC;
        else model_add(b);
      end
      M_ESC: begin
        if (b == 8'hDC) model_add(8'hC0);
        else if (b == 8'hDD) model_add(8'hDB);
        else begin
          model_err(1'b0);
          m_mode = (b == 8'hC0) ? M_DATA : M_DROP;
        end
      end
      default: if (b == 8'hC0) m_mode = M_DATA;
    endcase
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    in_d = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    checks++;
    if (t >= 200) begin
      errors++;
      $display("FAIL accept_timeout byte=%h in_ready=%b required 1", b, in_ready);
    end else begin
      model_byte(b);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    @(negedge clk);
    while (out_valid && t < 200) begin
      t++;
      @(negedge clk);
    end
    checks++;
    if (t >= 200) begin
      errors++;
      $display("FAIL drain_timeout out_valid=%b required 0", out_valid);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, out_last, out_err, out_d, frame_done, frame_len, err_esc, err_overlen, frame_cnt, err_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs valid=%b last=%b err=%b d=%h done=%b len=%0d esc=%b ovl=%b fcnt=%0d ecnt=%0d required all 0",
               out_valid, out_last, out_err, out_d, frame_done, frame_len, err_esc, err_overlen, frame_cnt, err_cnt);
    end
    model_reset();
    rst = 1'b0;
    enable = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_basic();
    logic [7:0] s1[5];
    logic [7:0] s2[7];
    logic [7:0] s3[3];
    s1 = '{8'hC0, 8'h01, 8'h02, 8'h03, 8'hC0};
    foreach (s1[i]) send_byte(s1[i]);
    drain();
    checks++;
    if (frame_len !== CNT_W'(3) || frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL basic_len_cnt len=%0d cnt=%0d required 3 1", frame_len, frame_cnt);
    end
    apply_reset();
    s2 = '{8'h55, 8'hC0, 8'hDB, 8'hDC, 8'hDB, 8'hDD, 8'hC0};
    foreach (s2[i]) send_byte(s2[i]);
    s3 = '{8'hC0, 8'hC0, 8'hC0};
    foreach (s3[i]) send_byte(s3[i]);
    drain();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL basic_count got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL basic_byte[%0d] got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (frame_len !== CNT_W'(m_len) || frame_cnt !== m_frames || s_done != m_done) begin
      errors++;
      $display("FAIL basic_stats len=%0d cnt=%0d pulses=%0d required %0d %0d %0d", frame_len, frame_cnt, s_done, m_len, m_frames, m_done);
    end
  endtask

  task automatic test_errors();
    logic [7:0] s[16];
    s = '{8'hC0, 8'hAA, 8'hDB, 8'h11, 8'hBB, 8'hC0, 8'h77, 8'hC0,
          8'hC0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'hC0};
    got_q.delete(); exp_q.delete();
    foreach (s[i]) send_byte(s[i]);
    drain();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL err_count got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL err_byte[%0d] got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (err_cnt !== m_errs || s_esc != m_esc || s_ovl != m_ovl || frame_cnt !== m_frames) begin
      errors++;
      $display("FAIL err_stats ecnt=%0d esc=%0d ovl=%0d fcnt=%0d required %0d %0d %0d %0d",
               err_cnt, s_esc, s_ovl, frame_cnt, m_errs, m_esc, m_ovl, m_frames);
    end
  endtask

  task automatic test_stall();
    logic [7:0] s[3];
    s = '{8'hC0, 8'h01, 8'h02};
    got_q.delete(); exp_q.delete();
    ready_mode = 2;
    @(posedge clk);
    #2;
    foreach (s[i]) send_byte(s[i]);
    in_d = 8'h03;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_d !== 8'h01) begin
        errors++;
        $display("FAIL stall[%0d] in_ready=%b valid=%b d=%h required 0 1 01", i, in_ready, out_valid, out_d);
      end
    end
    ready_mode = 0;
    send_byte(8'h03);
    send_byte(8'hC0);
    drain();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL stall_count got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL stall_byte[%0d] got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    int r;
    got_q.delete(); exp_q.delete();
    ready_mode = 1;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 15);
      case (r)
        0, 1:    b = 8'hC0;
        2, 3:    b = 8'hDB;
        4:       b = 8'hDC;
        5:       b = 8'hDD;
        default: b = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 9) == 0) begin
        enable = 1'b0;
        in_d = b;
        in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL disabled_ready in_ready=%b required 0", in_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        enable = 1'b1;
      end
      send_byte(b);
    end
    send_byte(8'hC0);
    ready_mode = 0;
    drain();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_count got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rand_byte[%0d] got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (frame_cnt !== m_frames || err_cnt !== m_errs || frame_len !== CNT_W'(m_len) ||
        s_done != m_done || s_esc != m_esc || s_ovl != m_ovl) begin
      errors++;
      $display("FAIL rand_stats fcnt=%0d ecnt=%0d len=%0d done=%0d esc=%0d ovl=%0d required %0d %0d %0d %0d %0d %0d",
               frame_cnt, err_cnt, frame_len, s_done, s_esc, s_ovl, m_frames, m_errs, m_len, m_done, m_esc, m_ovl);
    end
  endtask

  task automatic test_midframe_reset();
    logic [7:0] s[4];
    send_byte(8'hC0);
    send_byte(8'h44);
    send_byte(8'h55);
    #2;
    apply_reset();
    s = '{8'h66, 8'hC0, 8'h77, 8'hC0};
    foreach (s[i]) send_byte(s[i]);
    drain();
    checks++;
    if (got_q.size() != 1) begin
      errors++;
      $display("FAIL rst_count got %0d required 1", got_q.size());
    end else begin
      held_d = got_q[0][9:2];
      checks++;
      if (got_q[0] !== exp_q[0] || held_d !== 8'h77) begin
        errors++;
        $display("FAIL rst_byte got %h required %h", got_q[0], exp_q[0]);
      end
    end
    checks++;
    if (frame_cnt !== 16'd1 || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rst_stats fcnt=%0d ecnt=%0d required 1 0", frame_cnt, err_cnt);
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_errors();
    test_stall();
    test_random();
    test_midframe_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
